perf_counter_unit: RTL and testbench

//  Performance-counter block directly downstream of the riscv core. It consumes the core's
//  one-cycle stat_* event strobes and counts each one, plus a 64-bit cycle count. Software
//  and the testbench read the counters through a small register port with 1-cycle read latency.
//  The port controls enable, clear, halt-on-ecall and a sticky overflow status.

---
 rtl/perf_counter_unit.sv | 210 +++++++++++++++++++++
 tb/tb_perf_counter_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
// Performance-counter unit.
// Counts the core's one-cycle event strobes and free-running cycles, and exposes
// them through a 16-word register port with one cycle of read latency.
// Software controls enable, clear, halt-on-ecall, overflow status and the
// overflow interrupt enable through the same port.
module perf_counter_unit #(
    parameter int          CNT_W       = 32,     // event counter width, 8..32
    parameter int          NUM_EV      = 12,     // fixed to the ev_i bit map
    // Cycle counter value loaded by rst. Keep at 0 in silicon; a non-zero
    // preload lets a bench reach the 32-bit carry without 2^32 cycles.
    parameter logic [63:0] CYC_RST_VAL = 64'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_EV-1:0] ev_i,
    input  logic              csr_sel,
    input  logic              csr_we,
    input  logic [3:0]        csr_addr,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    output logic              csr_rvalid,
    output logic              ovf_irq
);

    // Register map word indices above the per-event counters.
    localparam logic [3:0] ADDR_CYC_LO = 4'd12;
    localparam logic [3:0] ADDR_CYC_HI = 4'd13;
    localparam logic [3:0] ADDR_CTRL   = 4'd14;
    localparam logic [3:0] ADDR_OVF    = 4'd15;

    // ev_i bit carrying the ecall strobe.
    localparam int ECALL_BIT = 11;

    // CTRL field positions.
    localparam int CTRL_EN     = 0;
    localparam int CTRL_HALT   = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_OVF_IE = 3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_evcnt [NUM_EV];
    logic [63:0]      r_cyc;
    logic [31:0]      r_hi_shadow;
    logic [NUM_EV:0]  r_ovf;          // [NUM_EV] is the cycle counter
    logic             r_en;
    logic             r_halt;
    logic             r_ovf_ie;
    logic [31:0]      r_rdata;
    logic             r_rvalid;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_rd;
    logic w_wr;
    logic w_wr_ctrl;
    logic w_wr_ovf;
    logic w_clr;
    logic w_rd_cyc_lo;
    logic w_halt_now;

    assign w_rd        = csr_sel & ~csr_we;
    assign w_wr        = csr_sel &  csr_we;
    assign w_wr_ctrl   = w_wr & (csr_addr == ADDR_CTRL);
    assign w_wr_ovf    = w_wr & (csr_addr == ADDR_OVF);
    assign w_clr       = w_wr_ctrl & csr_wdata[CTRL_CLR];
    assign w_rd_cyc_lo = w_rd & (csr_addr == ADDR_CYC_LO);

    // An ecall retires while halting is armed: it is still counted this edge,
    // and en drops so nothing counts afterwards.
    assign w_halt_now  = r_en & r_halt & ev_i[ECALL_BIT];

    // Upper write-data bits have no register behind them.
    logic w_unused;
    assign w_unused = &{1'b0, csr_wdata[31:NUM_EV+1]};

    // ------------------------------------------------------------------
    // Wrap detection: a counter sitting at all-ones that increments this
    // edge rolls to zero and raises its overflow bit on the same edge.
    // ------------------------------------------------------------------
    logic [NUM_EV:0] w_ovf_set;

    // Flag every counter that is about to roll over.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_ovf_set = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            w_ovf_set[i] = r_en & ev_i[i] & (&r_evcnt[i]);
        end
        w_ovf_set[NUM_EV] = r_en & (&r_cyc);
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------

    // Event and cycle counters: clear wins over counting, counting needs en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is a bank of flops, not a RAM, so every slot is reset here.
            for (int i = 0; i < NUM_EV; i++) begin
                r_evcnt[i] <= '0;
            end
            r_cyc <= CYC_RST_VAL;
        end else if (w_clr) begin
            // Events arriving with the clear are dropped on purpose.
            for (int i = 0; i < NUM_EV; i++) begin
                r_evcnt[i] <= '0;
            end
            r_cyc <= '0;
        end else if (r_en) begin
            for (int i = 0; i < NUM_EV; i++) begin
                if (ev_i[i]) begin
                    // NOTE: non-blocking so every register in this block updates from pre-edge values.
                    r_evcnt[i] <= r_evcnt[i] + CNT_W'(1);
                end
            end
            r_cyc <= r_cyc + 64'd1;
        end
    end

    // Sticky overflow status: write-1-to-clear, but a fresh wrap on the same
    // edge keeps its bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
        end else if (w_clr) begin
            r_ovf <= '0;
        end else if (w_wr_ovf) begin
            r_ovf <= (r_ovf & ~csr_wdata[NUM_EV:0]) | w_ovf_set;
        end else begin
            r_ovf <= r_ovf | w_ovf_set;
        end
    end

    // Upper cycle word snapshot taken by a CYC_LO read, so LO then HI reads
    // form one coherent 64-bit value even across a carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_shadow <= '0;
        end else if (w_clr) begin
            r_hi_shadow <= '0;
        end else if (w_rd_cyc_lo) begin
            r_hi_shadow <= r_cyc[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------

    // CTRL fields; an explicit software write takes precedence over the
    // halt-on-ecall auto-disable in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b1;
            r_halt   <= 1'b0;
            r_ovf_ie <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en     <= csr_wdata[CTRL_EN];
            r_halt   <= csr_wdata[CTRL_HALT];
            r_ovf_ie <= csr_wdata[CTRL_OVF_IE];
        end else if (w_halt_now) begin
            r_en     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    logic [31:0] w_rd_mux;

    // Select the pre-edge value of the addressed register.
    always_comb begin
        w_rd_mux = '0;
        if (csr_addr < 4'(NUM_EV)) begin
            w_rd_mux[CNT_W-1:0] = r_evcnt[csr_addr];
        end else begin
            case (csr_addr)
                ADDR_CYC_LO: w_rd_mux = r_cyc[31:0];
                ADDR_CYC_HI: w_rd_mux = r_hi_shadow;
                ADDR_CTRL: begin
                    w_rd_mux[CTRL_EN]     = r_en;
                    w_rd_mux[CTRL_HALT]   = r_halt;
                    w_rd_mux[CTRL_OVF_IE] = r_ovf_ie;
                end
                ADDR_OVF:    w_rd_mux[NUM_EV:0] = r_ovf;
                default:     w_rd_mux = '0;
            endcase
        end
    end

    // Register read data for one cycle; data is forced to zero without rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rdata  <= w_rd ? w_rd_mux : 32'd0;
            r_rvalid <= w_rd;
        end
    end

    assign csr_rdata  = r_rdata;
    assign csr_rvalid = r_rvalid;
    assign ovf_irq    = r_ovf_ie & (|r_ovf);

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: directed steps plus a randomized stretch, all
// compared cycle by cycle against a behavioural model of the register map.
module tb_perf_counter_unit;

    localparam int              CNT_W       = 8;
    localparam logic [63:0]     CYC_PRELOAD = 64'h0000_0001_FFFF_FFF0;
    localparam longint unsigned CNT_MOD     = 64'd1 << CNT_W;

    localparam logic [3:0] A_CYC_LO = 4'd12;
    localparam logic [3:0] A_CYC_HI = 4'd13;
    localparam logic [3:0] A_CTRL   = 4'd14;
    localparam logic [3:0] A_OVF    = 4'd15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ev_i = '0;
    logic        csr_sel = 1'b0;
    logic        csr_we = 1'b0;
    logic [3:0]  csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        ovf_irq;

    int n_assert = 0;
    int n_fail   = 0;

    perf_counter_unit #(
        .CNT_W      (CNT_W),
        .NUM_EV     (12),
        .CYC_RST_VAL(CYC_PRELOAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_i      (ev_i),
        .csr_sel   (csr_sel),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_rvalid(csr_rvalid),
        .ovf_irq   (ovf_irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: plain counts, modulo arithmetic, explicit fields
    // ------------------------------------------------------------------
    longint unsigned m_cnt [12];
    longint unsigned m_cyc;
    logic [31:0]     m_hi;
    logic [12:0]     m_ovf;
    bit              m_en, m_halt, m_ie;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 12; i++) m_cnt[i] = 0;
        m_cyc  = CYC_PRELOAD;
        m_hi   = '0;
        m_ovf  = '0;
        m_en   = 1'b1;
        m_halt = 1'b0;
        m_ie   = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        logic [31:0] v;
        v = '0;
        if (addr < 4'd12)        v = 32'(m_cnt[addr]);
        else if (addr == A_CYC_LO) v = m_cyc[31:0];
        else if (addr == A_CYC_HI) v = m_hi;
        else if (addr == A_CTRL)   v = {28'd0, m_ie, 1'b0, m_halt, m_en};
        else                       v = {19'd0, m_ovf};
        return v;
    endfunction

    task automatic model_step(input logic [11:0] ev, input logic sel, input logic we,
                              input logic [3:0] addr, input logic [31:0] wd);
        logic [12:0] set;
        bit wr_ctrl, clr;
        set     = '0;
        wr_ctrl = sel && we && (addr == A_CTRL);
        clr     = wr_ctrl && wd[2];
        if (sel && !we && addr == A_CYC_LO) m_hi = m_cyc[63:32];
        if (clr) begin
            for (int i = 0; i < 12; i++) m_cnt[i] = 0;
            m_cyc = 0;
            m_hi  = '0;
            m_ovf = '0;
        end else begin
            if (m_en) begin
                for (int i = 0; i < 12; i++) begin
                    if (ev[i]) begin
                        m_cnt[i] = (m_cnt[i] + 1) % CNT_MOD;
                        if (m_cnt[i] == 0) set[i] = 1'b1;
                    end
                end
                m_cyc = m_cyc + 1;
                if (m_cyc == 0) set[12] = 1'b1;
            end
            if (sel && we && addr == A_OVF) m_ovf = m_ovf & ~wd[12:0];
            m_ovf = m_ovf | set;
        end
        if (wr_ctrl) begin
            m_en   = wd[0];
            m_halt = wd[1];
            m_ie   = wd[3];
        end else if (m_en && m_halt && ev[11]) begin
            m_en = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, step the model, then check the
    // outputs at the next falling edge.
    task automatic tick(input logic [11:0] ev, input logic sel, input logic we,
                        input logic [3:0] addr, input logic [31:0] wd);
        logic        exp_v;
        logic [31:0] exp_d;
        ev_i      = ev;
        csr_sel   = sel;
        csr_we    = we;
        csr_addr  = addr;
        csr_wdata = wd;
        exp_v = sel && !we;
        exp_d = exp_v ? model_read(addr) : 32'd0;
        model_step(ev, sel, we, addr, wd);
        @(posedge clk);
        @(negedge clk);
        ev_i    = '0;
        csr_sel = 1'b0;
        csr_we  = 1'b0;
        check($sformatf("rvalid(a=%0d)", addr), 64'(csr_rvalid), 64'(exp_v));
        check($sformatf("rdata(a=%0d)", addr), 64'(csr_rdata), 64'(exp_d));
        check("ovf_irq", 64'(ovf_irq), 64'(m_ie && (|m_ovf)));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick('0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        tick('0, 1'b1, 1'b1, addr, data);
    endtask

    task automatic pulses(input logic [11:0] ev, input int n);
        for (int k = 0; k < n; k++) tick(ev, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic rd_expect(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        tick('0, 1'b1, 1'b0, addr, 32'd0);
        check(tag, 64'(csr_rdata), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] frozen;
        logic [11:0] ev;
        logic [31:0] wd;
        int          op;

        // Reset state while rst is high.
        model_reset();
        @(negedge clk);
        check("reset rvalid", 64'(csr_rvalid), 64'd0);
        check("reset rdata", 64'(csr_rdata), 64'd0);
        check("reset ovf_irq", 64'(ovf_irq), 64'd0);
        rst = 1'b0;

        // CTRL reads 0x1, every event counter reads 0.
        rd_expect(A_CTRL, 32'h1, "ctrl after reset");
        for (int i = 0; i < 12; i++) rd_expect(4'(i), 32'd0, $sformatf("evcnt%0d after reset", i));

        // Event 0 x5 and event 6 x3, two of those cycles overlapping.
        pulses(12'h041, 2);
        pulses(12'h001, 3);
        pulses(12'h040, 1);
        rd_expect(4'd0, 32'd5, "evcnt0 counts");
        rd_expect(4'd6, 32'd3, "evcnt6 counts");
        rd_expect(4'd1, 32'd0, "evcnt1 untouched");

        // Disabled counting holds, re-enabled counting resumes.
        wr(A_CTRL, 32'h0);
        pulses(12'h100, 4);
        rd_expect(4'd8, 32'd0, "evcnt8 held while disabled");
        frozen = m_cyc[31:0];
        rd_expect(A_CYC_LO, frozen, "cycle held while disabled");
        wr(A_CTRL, 32'h1);
        pulses(12'h100, 4);
        rd_expect(4'd8, 32'd4, "evcnt8 after enable");
        wr(4'd8, 32'hFF);
        rd_expect(4'd8, 32'd4, "evcnt write ignored");

        // 8-bit wrap sets OVF; W1C racing a new wrap keeps the new bit.
        wr(A_CTRL, 32'h5);
        pulses(12'h002, 256);
        rd_expect(4'd1, 32'd0, "evcnt1 wrapped");
        rd_expect(A_OVF, 32'h002, "ovf after wrap");
        pulses(12'h004, 255);
        tick(12'h004, 1'b1, 1'b1, A_OVF, 32'h002);
        rd_expect(A_OVF, 32'h004, "ovf w1c vs set");
        wr(A_CTRL, 32'h9);
        check("ovf_irq with ie", 64'(ovf_irq), 64'd1);

        // Halt on ecall: the ecall counts, en drops, counters freeze.
        wr(A_CTRL, 32'h3);
        tick(12'h801, 1'b0, 1'b0, 4'd0, 32'd0);
        rd_expect(A_CTRL, 32'h2, "ctrl en cleared by ecall");
        rd_expect(4'd11, 32'd1, "ecall counted");
        frozen = 32'(m_cnt[0]);
        pulses(12'h001, 10);
        rd_expect(4'd0, frozen, "evcnt0 frozen");
        frozen = m_cyc[31:0];
        idle(10);
        rd_expect(A_CYC_LO, frozen, "cycle frozen");
        // A CTRL write in the ecall cycle overrides the auto-disable.
        wr(A_CTRL, 32'h3);
        tick(12'h800, 1'b1, 1'b1, A_CTRL, 32'h3);
        rd_expect(A_CTRL, 32'h3, "ctrl write beats halt");
        wr(A_CTRL, 32'h1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            ev = 12'($urandom);
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                tick(ev, 1'b1, 1'b0, 4'($urandom), 32'd0);
            end else if (op == 6) begin
                wd = {28'd0, 1'($urandom), ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0)};
                tick(ev, 1'b1, 1'b1, A_CTRL, wd);
            end else if (op == 7) begin
                tick(ev, 1'b1, 1'b1, A_OVF, $urandom);
            end else if (op == 8) begin
                tick(ev, 1'b1, 1'b1, 4'($urandom_range(0, 11)), $urandom);
            end else begin
                tick(ev, 1'b0, 1'b0, 4'd0, 32'd0);
            end
        end

        // Atomic 64-bit read across the 32-bit carry, from the preload value.
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 64 && m_cyc != 64'h1_FFFF_FFFF; k++) idle(1);
        rd_expect(A_CYC_LO, 32'hFFFF_FFFF, "cyc lo before carry");
        idle(1);
        rd_expect(A_CYC_HI, 32'h1, "cyc hi from shadow");

        // Clear with a simultaneous event discards it.
        pulses(12'h00F, 3);
        tick(12'h008, 1'b1, 1'b1, A_CTRL, 32'h5);
        rd_expect(4'd3, 32'd0, "evcnt3 after clear");
        rd_expect(4'd0, 32'd0, "evcnt0 after clear");
        rd_expect(A_CYC_HI, 32'd0, "shadow after clear");
        rd_expect(A_OVF, 32'd0, "ovf after clear");
        rd_expect(A_CYC_LO, 32'd4, "cycle restarts after clear");

        // Asynchronous reset kills an in-flight read immediately.
        csr_sel  = 1'b1;
        csr_we   = 1'b0;
        csr_addr = A_CTRL;
        @(posedge clk);
        #1 rst = 1'b1;
        csr_sel = 1'b0;
        #1;
        check("rvalid during rst", 64'(csr_rvalid), 64'd0);
        check("rdata during rst", 64'(csr_rdata), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rd_expect(A_CTRL, 32'h1, "ctrl after mid-read reset");
        rd_expect(A_CYC_HI, 32'd0, "shadow after mid-read reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
